// File: rtl/fifo_common_pkg.sv
// Shared definitions for the FIFO write arbiter.
// Holds parameter defaults, the arbiter FSM state type and a
// modulo-increment helper used by the round-robin logic.
package fifo_common_pkg;

    localparam int unsigned NUM_REQ_DEFAULT    = 4;
    localparam int unsigned DATA_WIDTH_DEFAULT = 8;
    localparam int unsigned MAX_BURST_DEFAULT  = 4;

    // grant_id is always 3 bits wide (up to 8 requesters); burst_cnt is 4 bits.
    localparam int unsigned GRANT_W = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    // (base + offs) mod n, for indices that fit in GRANT_W bits.
    function automatic logic [GRANT_W-1:0] wrap_add(input logic [GRANT_W-1:0] base,
                                                   input int unsigned        offs,
                                                   input int unsigned        n);
        int unsigned sum;
        sum = 32'(base) + offs;
        return GRANT_W'(sum % n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the requester-side and FIFO-side signals of the write arbiter.
//   req          per-requester write request
//   req_data     per-requester write word, slice i belongs to requester i
//   ack          per-requester transfer accept
//   full         FIFO full flag
//   write_enable FIFO write strobe
//   data_in      FIFO write data
//   grant_id     current/selected owner index
//   busy         high while a burst owner is locked
// Modport master: the arbiter. Modport slave: requesters plus FIFO.
interface fifo_wr_arbiter_if
    import fifo_common_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          full;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [GRANT_W-1:0]            grant_id;
    logic                          busy;

    modport master (
        input  req,
        input  req_data,
        input  full,
        output ack,
        output write_enable,
        output data_in,
        output grant_id,
        output busy
    );

    modport slave (
        output req,
        output req_data,
        output full,
        input  ack,
        input  write_enable,
        input  data_in,
        input  grant_id,
        input  busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first requester with req set, starting at rr_ptr and
// wrapping upward. Purely combinational.
//   req     request vector
//   rr_ptr  search start index (< NUM_REQ)
//   found   some request is pending
//   index   selected requester (0 when nothing found)
module rr_pick
    import fifo_common_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] index
);

    // Padded to 8 entries so a 3-bit index selects it exactly.
    logic [7:0]         req_pad;
    logic [GRANT_W-1:0] cand;

    always_comb begin
        req_pad = 8'(req);
        found   = 1'b0;
        index   = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr, k, NUM_REQ);
            if (!found && req_pad[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO. The winner gets a burst of up
// to MAX_BURST consecutive writes; ack, write_enable and data_in are
// combinational (zero latency) from req/full and the arbiter state.
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset; also forces all outputs to zero
//   bus    master side of fifo_wr_arbiter_if (see interface for signals)
module fifo_wr_arbiter
    import fifo_common_pkg::*;
#(
    parameter int unsigned NUM_REQ    = NUM_REQ_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned MAX_BURST  = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] owner_q, owner_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic [7:0]         req_pad;
    logic [CNT_W-1:0]   cnt_inc;
    logic [NUM_REQ-1:0] ack_int;
    logic [GRANT_W-1:0] grant_int;

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req   (bus.req),
        .rr_ptr(rr_ptr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        ack_int     = '0;
        grant_int   = owner_q;
        req_pad     = 8'(bus.req);
        cnt_inc     = burst_cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                grant_int = pick_idx;
                if (!bus.full && pick_found) begin
                    ack_int = NUM_REQ'(1) << pick_idx;
                    if (MAX_BURST == 1) begin
                        // Single-word bursts: rotate straight away, never lock.
                        rr_ptr_d = wrap_add(pick_idx, 1, NUM_REQ);
                    end else begin
                        state_d     = StBurst;
                        owner_d     = pick_idx;
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
            StBurst: begin
                // Owner dropping req releases the grant even while full is high.
                if (!req_pad[owner_q]) begin
                    state_d     = StIdle;
                    rr_ptr_d    = wrap_add(owner_q, 1, NUM_REQ);
                    burst_cnt_d = '0;
                end else if (!bus.full) begin
                    ack_int = NUM_REQ'(1) << owner_q;
                    if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        state_d     = StIdle;
                        rr_ptr_d    = wrap_add(owner_q, 1, NUM_REQ);
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end
            end
        endcase
    end

    always_comb begin
        bus.ack          = '0;
        bus.write_enable = 1'b0;
        bus.data_in      = '0;
        bus.grant_id     = '0;
        bus.busy         = 1'b0;
        if (rst_n) begin
            bus.ack          = ack_int;
            bus.write_enable = |ack_int;
            bus.grant_id     = grant_int;
            bus.busy         = (state_q == StBurst);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (ack_int[i]) begin
                    bus.data_in = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter. A rule-level model predicts every
// cycle's outputs; per-scenario grant sequences are also pinned by hand.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(W),
        .MAX_BURST (MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    string       scen     = "init";
    bit          checking = 1'b0;
    int          words     [N];
    int          start_cyc [N];
    logic [W-1:0] wdata    [N];
    logic [31:0] full_mask;
    logic [31:0] rst_mask;
    int          dut_log[$];
    int          mdl_log[$];

    // Model: arbitration rules expressed with plain integers.
    bit m_burst = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%s] cycle %0d: got %0h, want %0h", name, scen, cyc, act, exp);
    endtask

    always @(negedge clk) begin : compare
        int           sel;
        int           exp_gid;
        int           dut_idx;
        int           nb;
        bit           exp_busy;
        logic [N-1:0] req_now;
        logic [N-1:0] exp_ack;
        logic [W-1:0] exp_data;
        if (checking) begin
            req_now  = bus.req;
            sel      = -1;
            exp_busy = 1'b0;
            exp_gid  = 0;
            if (!rst_n) begin
                m_burst = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            end else if (!m_burst) begin
                if (!bus.full) begin
                    for (int k = 0; k < N; k++) begin
                        if (sel < 0 && req_now[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
                    end
                end
                exp_gid = (sel < 0) ? 0 : sel;
                if (sel >= 0) begin
                    if (MB == 1) m_ptr = (sel + 1) % N;
                    else begin m_burst = 1'b1; m_owner = sel; m_cnt = 1; end
                end
            end else begin
                exp_busy = 1'b1;
                exp_gid  = m_owner;
                if (!req_now[m_owner]) begin
                    m_burst = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
                end else if (!bus.full) begin
                    sel = m_owner;
                    m_cnt++;
                    if (m_cnt == MB) begin
                        m_burst = 1'b0; m_ptr = (m_owner + 1) % N; m_cnt = 0;
                    end
                end
            end
            exp_ack  = (sel < 0) ? '0 : (N'(1) << sel);
            exp_data = (sel < 0) ? '0 : wdata[sel];
            check("ack",          32'(bus.ack),          32'(exp_ack));
            check("write_enable", 32'(bus.write_enable), 32'(sel >= 0));
            check("data_in",      32'(bus.data_in),      32'(exp_data));
            check("busy",         32'(bus.busy),         32'(exp_busy));
            if (!rst_n || exp_busy || sel >= 0)
                check("grant_id", 32'(bus.grant_id), 32'(exp_gid));

            dut_idx = -1;
            if (bus.write_enable === 1'b1) begin
                nb = 0;
                for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) begin nb++; dut_idx = i; end
                if (nb != 1) dut_idx = 99;
            end
            dut_log.push_back(dut_idx);
            mdl_log.push_back(sel);
        end
    end

    task automatic load(input int w0, input int w1, input int w2, input int w3,
                        input int s0, input int s1, input int s2, input int s3);
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        start_cyc[0] = s0; start_cyc[1] = s1; start_cyc[2] = s2; start_cyc[3] = s3;
        for (int i = 0; i < N; i++) wdata[i] = 8'hA0 + 8'(i);
    endtask

    task automatic run(input int ncyc);
        logic [N-1:0] a;
        dut_log.delete();
        mdl_log.delete();
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = wdata[i];
        for (int c = 0; c < ncyc; c++) begin
            cyc      = c;
            rst_n    = !rst_mask[c];
            bus.full = full_mask[c];
            for (int i = 0; i < N; i++) bus.req[i] = (words[i] > 0) && (c >= start_cyc[i]);
            @(negedge clk);
            a = bus.ack;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (a[i] === 1'b1 && words[i] > 0) words[i]--;
        end
    endtask

    // '.' = no write that cycle, digit = index of the acked requester.
    task automatic check_seq(input string s);
        int nm_d;
        int nm_m;
        int e;
        nm_d = (dut_log.size() != s.len()) ? 1 : 0;
        nm_m = (mdl_log.size() != s.len()) ? 1 : 0;
        for (int k = 0; k < s.len(); k++) begin
            e = (s[k] == 8'h2E) ? -1 : int'(s[k]) - 48;
            if (k < dut_log.size() && dut_log[k] != e) nm_d++;
            if (k < mdl_log.size() && mdl_log[k] != e) nm_m++;
        end
        check("model_sequence", 32'(nm_m), 32'd0);
        check("dut_sequence",   32'(nm_d), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.full     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;

        // Reset held two cycles with every requester asking.
        scen = "reset"; load(4, 4, 4, 4, 0, 0, 0, 0);
        full_mask = '0; rst_mask = 32'h3;
        run(2); check_seq("..");

        // Lone requester 2, four writes of A5, then quiet.
        scen = "single"; load(0, 0, 4, 0, 0, 0, 0, 0); wdata[2] = 8'hA5;
        full_mask = '0; rst_mask = '0;
        run(6); check_seq("2222..");

        // All four requesting: 0,1,2,3,0 in four-write bursts.
        scen = "round_robin"; load(8, 8, 8, 8, 0, 0, 0, 0);
        full_mask = '0; rst_mask = 32'h1;
        run(21); check_seq(".00001111222233330000");

        // Full for three cycles after owner 1's second write.
        scen = "backpressure"; load(0, 4, 4, 0, 0, 0, 0, 0);
        full_mask = 32'h38; rst_mask = 32'h1;
        run(13); check_seq(".11...112222.");

        // Owner 3 leaves after one word; requester 0 follows after a gap.
        scen = "early_release"; load(2, 0, 0, 1, 2, 0, 0, 0);
        full_mask = '0; rst_mask = 32'h1;
        run(7); check_seq(".3.00..");

        // Reset right after owner 2's second write; restart picks 1 first.
        scen = "mid_reset"; load(0, 2, 4, 0, 0, 4, 0, 0);
        full_mask = '0; rst_mask = 32'h9;
        run(11); check_seq(".22.11.22..");

        // Full in idle holds off; full with owner gone still releases.
        scen = "full_release"; load(1, 1, 0, 0, 0, 3, 0, 0);
        full_mask = 32'hA; rst_mask = 32'h1;
        run(7); check_seq("..0.1..");

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
